tdm_demux14_4: RTL and testbench
================================

Name: tdm_demux14_4

Overview:
Receive end of the 4-lane time-division link whose transmit end time-multiplexes four WIDTH-bit words (w0..w3) onto one bus with a 4:1 mux.
- Accepts one word per valid cycle, with a start-of-frame marker on slot 0.
- Collects four slots and presents them in parallel on y0..y3 with a one-cycle frame_valid pulse.
- Detects framing errors: orphan words, early restart, inter-slot timeout.

Parameters:
- WIDTH, 4, bit width of each slot word and each output lane.
- TIMEOUT, 8, max idle cycles between slots inside a frame before abort; 0 disables the timeout.

Ports:
- clk, input, 1, single clock, all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- din, input, WIDTH, multiplexed slot word.
- din_valid, input, 1, din carries a slot this cycle.
- sof, input, 1, qualifies din as slot 0; ignored when din_valid=0.
- y0..y3, output, WIDTH each, registered demultiplexed lanes of the last complete frame.
- frame_valid, output, 1, one-cycle pulse when y0..y3 update.
- busy, output, 1, high while in COLLECT.
- slot, output, 2, index of the next expected slot (0..3).
- err_drop, output, 1, pulse: din_valid without sof while IDLE, word discarded.
- err_resync, output, 1, pulse: sof arrived mid-frame, frame restarted.
- err_timeout, output, 1, pulse: inter-slot gap exceeded TIMEOUT, frame aborted.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, slot=0, gap counter=0, shadow regs=0.
  - y0..y3=0; frame_valid, busy and all err_* = 0.
- FSM states: IDLE, COLLECT. busy = (state==COLLECT).
- IDLE:
  - din_valid & sof: shadow[0]<=din, slot<=1, go COLLECT.
  - din_valid & !sof: discard, err_drop=1 next cycle, stay IDLE.
  - !din_valid: hold.
- COLLECT:
  - din_valid & sof: shadow[0]<=din, slot<=1, gap<=0, err_resync=1 next cycle, stay COLLECT. The partial frame is lost and y0..y3 are unchanged.
  - din_valid & !sof & slot<3: shadow[slot]<=din, slot<=slot+1, gap<=0.
  - din_valid & !sof & slot==3:
    - y0..y2 <= shadow[0..2] and y3 <= din, same edge.
    - frame_valid=1 for exactly the next cycle.
    - slot<=0, go IDLE.
  - !din_valid: gap<=gap+1. When TIMEOUT!=0 and gap reaches TIMEOUT: go IDLE, slot<=0, err_timeout=1 next cycle, y unchanged.
- Latency: y0..y3 and frame_valid change on the clock edge that accepts slot 3, so they are visible one cycle after that slot is presented.
- Back-to-back frames: the cycle right after slot 3 may carry the next sof. It is accepted from IDLE with no bubble, and frame_valid of frame N overlaps slot 0 of frame N+1.
- Outputs y0..y3 hold their value until the next complete frame. Error pulses never alter y.
- All pulse outputs are registered, one cycle wide, and mutually exclusive by construction.
- Reset mid-frame discards the partial frame immediately (asynchronous). No frame_valid is issued for it.
- Widths: slot counter 2 bits, wraps 3->0 only via frame completion. Gap counter is sized $clog2(TIMEOUT+1) and saturates, never wraps.

Decomposition:
- Shared include/package:
  - State encoding constants ST_IDLE=1'b0, ST_COLLECT=1'b1.
  - SLOT_W=2 and NUM_SLOTS=4, reused by the transmit-side mux.
- One sub-module, tdm_gap_timer:
  - Parameterised by TIMEOUT; inputs clk, rst_n, clear, count_en; output expired.
  - Keeps saturating-counter logic and the TIMEOUT=0 disable out of the FSM.

Test Plan:
- Basic frame: sof+0001, then 0010, 0000, 1000 on consecutive cycles -> one cycle after slot 3: y0=0001, y1=0010, y2=0000, y3=1000, frame_valid=1 for one cycle; busy falls.
- Gapped frame (TIMEOUT=8): slots 0011/1010/0011/1000 with 3 idle cycles between each -> same capture, y3=1000, no err_timeout.
- Timeout: sof+0100, 0010, then 8 idle cycles -> err_timeout pulse, busy=0, y holds the previous frame; the next word without sof -> err_drop.
- Resync: sof+0101, 0010, sof+0111, 0010, 0010, 0000 -> err_resync after the 3rd word, then y0=0111, y1=0010, y2=0010, y3=0000.
- Back-to-back: two frames (1000,0010,0100,0000) and (1001,0010,0000,0000) with no gap -> two frame_valid pulses 4 cycles apart, y0=1000 then 1001.
- Reset mid-frame: drop rst_n after slot 1 -> all outputs 0 immediately; after release, a fresh full frame 1100,0010,0000,0000 captures correctly.

Source files
------------

// File: rtl/tdm_demux14_4_pkg.sv
// Shared definitions for the 4-lane TDM link (transmit mux and receive demux).
package tdm_demux14_4_pkg;

  localparam int unsigned SLOT_W    = 2;
  localparam int unsigned NUM_SLOTS = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  // Index of the slot that completes a frame.
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

endpackage

// File: rtl/tdm_demux14_4_gap_timer.sv
// Saturating idle-cycle counter; flags the idle cycle that brings the gap up to TIMEOUT.
module tdm_demux14_4_gap_timer #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned SAT     = TIMEOUT;
  localparam int unsigned LAST_IX = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [CW-1:0] gap;

  // Clear wins over count; the counter sticks at TIMEOUT instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap <= '0;
    end else if (clear) begin
      gap <= '0;
    end else if (count_en && (gap != CW'(SAT))) begin
      gap <= gap + CW'(1);
    end
  end

  // Combinational so the FSM aborts on the same edge the gap reaches TIMEOUT.
  assign expired = (TIMEOUT != 0) && count_en && (gap == CW'(LAST_IX));

endmodule

// File: rtl/tdm_demux14_4.sv
// TDM receive demux: gathers four slot words into parallel lanes and flags framing errors.
module tdm_demux14_4
  import tdm_demux14_4_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  input  logic              sof,
  output logic [WIDTH-1:0]  y0,
  output logic [WIDTH-1:0]  y1,
  output logic [WIDTH-1:0]  y2,
  output logic [WIDTH-1:0]  y3,
  output logic              frame_valid,
  output logic              busy,
  output logic [SLOT_W-1:0] slot,
  output logic              err_drop,
  output logic              err_resync,
  output logic              err_timeout
);

  localparam int unsigned NUM_SHADOW = NUM_SLOTS - 1;

  state_e                  state, state_d;
  logic [SLOT_W-1:0]       slot_d;
  logic [WIDTH-1:0]        shadow   [NUM_SHADOW];
  logic [WIDTH-1:0]        shadow_d [NUM_SHADOW];
  logic [WIDTH-1:0]        y0_d, y1_d, y2_d, y3_d;
  logic                    frame_valid_d;
  logic                    err_drop_d, err_resync_d, err_timeout_d;
  logic                    gap_clear_c, gap_count_c, gap_expired_c;

  assign gap_clear_c = din_valid || (state == ST_IDLE);
  assign gap_count_c = (state == ST_COLLECT) && !din_valid;

  tdm_demux14_4_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (gap_clear_c),
    .count_en (gap_count_c),
    .expired  (gap_expired_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      slot        <= '0;
      for (int i = 0; i < int'(NUM_SHADOW); i++) shadow[i] <= '0;
      y0          <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
      frame_valid <= 1'b0;
      err_drop    <= 1'b0;
      err_resync  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      slot        <= slot_d;
      for (int i = 0; i < int'(NUM_SHADOW); i++) shadow[i] <= shadow_d[i];
      y0          <= y0_d;
      y1          <= y1_d;
      y2          <= y2_d;
      y3          <= y3_d;
      frame_valid <= frame_valid_d;
      err_drop    <= err_drop_d;
      err_resync  <= err_resync_d;
      err_timeout <= err_timeout_d;
    end
  end

  // Next-state and registered-output logic; every pulse is cleared by default.
  always_comb begin
    state_d       = state;
    slot_d        = slot;
    for (int i = 0; i < int'(NUM_SHADOW); i++) shadow_d[i] = shadow[i];
    y0_d          = y0;
    y1_d          = y1;
    y2_d          = y2;
    y3_d          = y3;
    frame_valid_d = 1'b0;
    err_drop_d    = 1'b0;
    err_resync_d  = 1'b0;
    err_timeout_d = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (din_valid) begin
          if (sof) begin
            shadow_d[0] = din;
            slot_d      = SLOT_W'(1);
            state_d     = ST_COLLECT;
          end else begin
            err_drop_d  = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (din_valid) begin
          if (sof) begin
            shadow_d[0]  = din;
            slot_d       = SLOT_W'(1);
            err_resync_d = 1'b1;
          end else if (slot == LAST_SLOT) begin
            y0_d          = shadow[0];
            y1_d          = shadow[1];
            y2_d          = shadow[2];
            y3_d          = din;
            frame_valid_d = 1'b1;
            slot_d        = '0;
            state_d       = ST_IDLE;
          end else begin
            for (int i = 0; i < int'(NUM_SHADOW); i++) begin
              if (slot == SLOT_W'(i)) shadow_d[i] = din;
            end
            slot_d = slot + SLOT_W'(1);
          end
        end else if (gap_expired_c) begin
          err_timeout_d = 1'b1;
          slot_d        = '0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_COLLECT);

endmodule

// File: tb/tb_tdm_demux14_4.sv
// Directed self-checking bench for tdm_demux14_4 (WIDTH=4, TIMEOUT=8).
module tb_tdm_demux14_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic       din_valid;
  logic       sof;
  logic [3:0] y0, y1, y2, y3;
  logic       frame_valid, busy;
  logic [1:0] slot;
  logic       err_drop, err_resync, err_timeout;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  tdm_demux14_4 #(.WIDTH(4), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .frame_valid (frame_valid),
    .busy        (busy),
    .slot        (slot),
    .err_drop    (err_drop),
    .err_resync  (err_resync),
    .err_timeout (err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // Present one bus cycle and return 1 time unit after the edge that consumed it.
  task automatic cyc(input logic v, input logic s, input logic [3:0] d);
    din_valid = v;
    sof       = s;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_y(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                       input logic [3:0] e2, input logic [3:0] e3);
    chk({tag, "_y0"}, 32'(y0), 32'(e0));
    chk({tag, "_y1"}, 32'(y1), 32'(e1));
    chk({tag, "_y2"}, 32'(y2), 32'(e2));
    chk({tag, "_y3"}, 32'(y3), 32'(e3));
  endtask

  task automatic chk_pulses(input string tag, input logic fv, input logic ed,
                            input logic er, input logic et);
    chk({tag, "_fv"}, 32'(frame_valid), 32'(fv));
    chk({tag, "_drop"}, 32'(err_drop), 32'(ed));
    chk({tag, "_resync"}, 32'(err_resync), 32'(er));
    chk({tag, "_timeout"}, 32'(err_timeout), 32'(et));
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_y("rst", 4'h0, 4'h0, 4'h0, 4'h0);
    chk_pulses("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_slot", 32'(slot), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame
    cyc(1, 1, 4'b0001);
    chk("basic_busy0", 32'(busy), 32'd1);
    chk("basic_slot0", 32'(slot), 32'd1);
    cyc(1, 0, 4'b0010);
    chk("basic_slot1", 32'(slot), 32'd2);
    cyc(1, 0, 4'b0000);
    chk("basic_fv_early", 32'(frame_valid), 32'd0);
    cyc(1, 0, 4'b1000);
    chk_y("basic", 4'b0001, 4'b0010, 4'b0000, 4'b1000);
    chk_pulses("basic", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("basic_busy_end", 32'(busy), 32'd0);
    chk("basic_slot_end", 32'(slot), 32'd0);
    cyc(0, 0, 4'b0000);
    chk("basic_fv_one", 32'(frame_valid), 32'd0);

    // Gapped frame: three idle cycles between slots stays under the timeout
    cyc(1, 1, 4'b0011);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'b0000);
    cyc(1, 0, 4'b1010);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'b0000);
    cyc(1, 0, 4'b0011);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 4'b0000);
      chk("gap_no_timeout", 32'(err_timeout), 32'd0);
    end
    chk("gap_busy", 32'(busy), 32'd1);
    chk("gap_y_hold", 32'(y0), 32'(4'b0001));
    cyc(1, 0, 4'b1000);
    chk_y("gap", 4'b0011, 4'b1010, 4'b0011, 4'b1000);
    chk_pulses("gap", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(0, 0, 4'b0000);

    // Timeout after 8 idle cycles
    cyc(1, 1, 4'b0100);
    cyc(1, 0, 4'b0010);
    for (int i = 0; i < 7; i++) cyc(0, 0, 4'b0000);
    chk("to_busy7", 32'(busy), 32'd1);
    chk("to_pulse7", 32'(err_timeout), 32'd0);
    cyc(0, 0, 4'b0000);
    chk_pulses("to", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_slot", 32'(slot), 32'd0);
    chk_y("to_hold", 4'b0011, 4'b1010, 4'b0011, 4'b1000);
    cyc(0, 0, 4'b0000);
    chk("to_one", 32'(err_timeout), 32'd0);
    cyc(1, 0, 4'b0101);
    chk_pulses("drop", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("drop_busy", 32'(busy), 32'd0);
    cyc(0, 0, 4'b0000);
    chk("drop_one", 32'(err_drop), 32'd0);

    // Resync: sof mid-frame restarts collection
    cyc(1, 1, 4'b0101);
    cyc(1, 0, 4'b0010);
    cyc(1, 1, 4'b0111);
    chk_pulses("rs", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rs_slot", 32'(slot), 32'd1);
    chk("rs_busy", 32'(busy), 32'd1);
    chk("rs_y_hold", 32'(y0), 32'(4'b0011));
    cyc(1, 0, 4'b0010);
    chk("rs_one", 32'(err_resync), 32'd0);
    cyc(1, 0, 4'b0010);
    cyc(1, 0, 4'b0000);
    chk_y("rs", 4'b0111, 4'b0010, 4'b0010, 4'b0000);
    chk_pulses("rs_done", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(0, 0, 4'b0000);

    // Back-to-back frames with no bubble
    cyc(1, 1, 4'b1000);
    cyc(1, 0, 4'b0010);
    cyc(1, 0, 4'b0100);
    cyc(1, 0, 4'b0000);
    chk_y("b2b1", 4'b1000, 4'b0010, 4'b0100, 4'b0000);
    chk("b2b1_fv", 32'(frame_valid), 32'd1);
    cyc(1, 1, 4'b1001);
    chk("b2b_fv_gap1", 32'(frame_valid), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_slot", 32'(slot), 32'd1);
    cyc(1, 0, 4'b0010);
    chk("b2b_fv_gap2", 32'(frame_valid), 32'd0);
    cyc(1, 0, 4'b0000);
    chk("b2b_fv_gap3", 32'(frame_valid), 32'd0);
    chk("b2b_y0_hold", 32'(y0), 32'(4'b1000));
    cyc(1, 0, 4'b0000);
    chk_y("b2b2", 4'b1001, 4'b0010, 4'b0000, 4'b0000);
    chk_pulses("b2b2", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(0, 0, 4'b0000);

    // Asynchronous reset mid-frame
    cyc(1, 1, 4'b1100);
    cyc(1, 0, 4'b0010);
    din_valid = 1'b0; sof = 1'b0; din = '0;
    #2 rst_n = 1'b0;
    #1;
    chk_y("arst", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_slot", 32'(slot), 32'd0);
    chk("arst_fv", 32'(frame_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_idle_fv", 32'(frame_valid), 32'd0);
    cyc(1, 1, 4'b1100);
    cyc(1, 0, 4'b0010);
    cyc(1, 0, 4'b0000);
    cyc(1, 0, 4'b0000);
    chk_y("post", 4'b1100, 4'b0010, 4'b0000, 4'b0000);
    chk_pulses("post", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(0, 0, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
